seg7_bcd_scan_driver: RTL and testbench

//  Parametrised multiplexed 7-segment driver: N digits, configurable value width, sequential binary->BCD conversion.

---
 rtl/seg7_bcd_scan_driver.sv | 238 +++++++++++++++++++++++
 tb/tb_seg7_bcd_scan_driver.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_scan_driver.sv
// Multiplexed 7-segment display driver with sequential binary-to-BCD conversion.
//
// A load strobe captures a binary value and a decimal-point mask. The value is converted to
// BCD by shift-add-3 (double-dabble), one input bit per clock. The finished result is committed
// to the display registers in a single cycle, so the scanned digits never show a mix of the
// old and new value. A free-running prescaler steps through the digits, one slot per CLK_DIV
// clocks.
//
// Ports:
//   clk      - system clock, all state on the rising edge
//   rst_n    - asynchronous active-low reset
//   value    - unsigned binary number to display, sampled on load
//   dp_mask  - decimal-point enables, bit i lights the dp of digit i, sampled on load
//   load     - single-cycle strobe; ignored while busy
//   busy     - conversion in progress
//   overflow - committed value does not fit in NUM_DIGITS decimal digits
//   seg      - segments {dp,g,f,e,d,c,b,a}, inverted when SEG_ACT_LOW
//   dig      - one-hot digit enable, active high, bit i = digit i (digit 0 is leftmost)
module seg7_bcd_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 3,
  parameter int unsigned VALUE_W     = 10,
  parameter int unsigned CLK_DIV     = 1000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(VALUE_W + 1);
  localparam int unsigned PreW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [7:0] SegOff = SEG_ACT_LOW ? 8'hFF : 8'h00;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] OvfLimit = pow10(NUM_DIGITS);

  function automatic logic [6:0] font7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Conversion state
  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [VALUE_W-1:0]    sh_q, sh_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic [BcdW-1:0]       bcd_adj;
  logic [NUM_DIGITS-1:0] dp_cap_q, dp_cap_d;
  logic                  ovf_cap_q, ovf_cap_d;

  // Committed display contents
  logic [BcdW-1:0]       disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  disp_ovf_q, disp_ovf_d;
  logic                  valid_q, valid_d;

  // Scan and output registers
  logic [PreW-1:0]       pre_q, pre_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [7:0]            raw;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    dp_cap_d   = dp_cap_q;
    ovf_cap_d  = ovf_cap_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;
    disp_ovf_d = disp_ovf_q;
    valid_d    = valid_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          sh_d      = value;
          dp_cap_d  = dp_mask;
          ovf_cap_d = (64'(value) >= OvfLimit);
          bcd_d     = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        // Digits beyond NUM_DIGITS fall off the top; overflow flags that case.
        bcd_d = {bcd_adj[BcdW-2:0], sh_q[VALUE_W-1]};
        sh_d  = sh_q << 1;
        if (cnt_q == CntW'(VALUE_W - 1)) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        disp_bcd_d = bcd_q;
        disp_dp_d  = dp_cap_q;
        disp_ovf_d = ovf_cap_q;
        valid_d    = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PreW'(CLK_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is blank while it and every digit to its left are zero; the last digit never is.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      zero_run = zero_run & (disp_bcd_q[4*(int'(NUM_DIGITS)-1-i) +: 4] == 4'd0);
      blank[i] = BLANK_LZ && zero_run && (i < int'(NUM_DIGITS) - 1);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = disp_bcd_q[4*(int'(NUM_DIGITS)-1-i) +: 4];
        cur_blank = blank[i];
        cur_dp    = disp_dp_q[i];
      end
    end
    raw = 8'h00;
    if (disp_ovf_q) begin
      raw[6:0] = 7'h40;
    end else if (!cur_blank) begin
      raw[6:0] = font7(cur_nib);
    end
    raw[7] = cur_dp;
    seg_d  = valid_q ? (SEG_ACT_LOW ? ~raw : raw) : SegOff;
    dig_d  = valid_q ? (NUM_DIGITS'(1) << idx_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      bcd_q      <= '0;
      dp_cap_q   <= '0;
      ovf_cap_q  <= 1'b0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      disp_ovf_q <= 1'b0;
      valid_q    <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SegOff;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      dp_cap_q   <= dp_cap_d;
      ovf_cap_q  <= ovf_cap_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      disp_ovf_q <= disp_ovf_d;
      valid_q    <= valid_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign overflow = disp_ovf_q;
  assign seg      = seg_q;
  assign dig      = dig_q;

endmodule

// File: tb/tb_seg7_bcd_scan_driver.sv
// Self-checking bench for seg7_bcd_scan_driver (3 digits, 10-bit value, short prescaler).
// Expected digit contents come from decimal arithmetic on the loaded value; the expected scan
// position comes from the number of clock edges since reset was released.
module tb_seg7_bcd_scan_driver;

  localparam int unsigned ND = 3;
  localparam int unsigned VW = 10;
  localparam int unsigned CD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] value = '0;
  logic [ND-1:0] dp_mask = '0;
  logic          load = 1'b0;
  logic          busy;
  logic          overflow;
  logic [7:0]    seg;
  logic [ND-1:0] dig;

  int tests_run = 0;
  int tests_failed = 0;

  // Model of what the display should currently show.
  bit            m_valid = 1'b0;
  int unsigned   m_val = 0;
  logic [ND-1:0] m_dp = '0;

  // Rising edges since reset was last released.
  int k;

  seg7_bcd_scan_driver #(
    .NUM_DIGITS (ND),
    .VALUE_W    (VW),
    .CLK_DIV    (CD),
    .SEG_ACT_LOW(1'b1),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .dp_mask (dp_mask),
    .load    (load),
    .busy    (busy),
    .overflow(overflow),
    .seg     (seg),
    .dig     (dig)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic int unsigned p10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] font(input int unsigned d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Output is registered, so after edge kk the digit shown is the slot of edge kk-1.
  function automatic int slot(input int kk);
    return ((kk - 1) / int'(CD)) % int'(ND);
  endfunction

  function automatic logic [ND-1:0] exp_dig(input int kk, input bit vld);
    logic [ND-1:0] one;
    one = 1;
    if (!vld || kk == 0) return '0;
    return one << slot(kk);
  endfunction

  function automatic logic [7:0] exp_seg(input int kk, input bit vld, input int unsigned val,
                                         input logic [ND-1:0] dp);
    logic [7:0] r;
    int i;
    if (!vld || kk == 0) return 8'hFF;
    i = slot(kk);
    r = 8'h00;
    if (val >= p10(ND)) begin
      r[6:0] = 7'h40;
    end else if (!(i < int'(ND) - 1 && val < p10(int'(ND) - 1 - i))) begin
      r[6:0] = font((val / p10(int'(ND) - 1 - i)) % 10);
    end
    r[7] = dp[i];
    return ~r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || dig !== '0 || seg !== 8'hFF || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: busy=%b dig=%b seg=%h ovf=%b, want 0/000/ff/0",
               busy, dig, seg, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
    for (int c = 0; c < 3 * int'(CD); c++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || dig !== '0 || seg !== 8'hFF || overflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle c=%0d: busy=%b dig=%b seg=%h ovf=%b, want 0/000/ff/0",
                 c, busy, dig, seg, overflow);
      end
    end
  endtask

  // Load one value, check busy timing and the held display, then a full scan of the new one.
  task automatic test_value(input int unsigned v, input logic [ND-1:0] dp);
    @(negedge clk);
    value = VW'(v);
    dp_mask = dp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int j = 0; j <= int'(VW); j++) begin
      if (j > 0) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_high v=%0d j=%0d: got %b want 1", v, j, busy);
      end
      tests_run++;
      if (dig !== exp_dig(k, m_valid) || seg !== exp_seg(k, m_valid, m_val, m_dp)) begin
        tests_failed++;
        $display("FAIL hold_old v=%0d j=%0d: dig=%b seg=%h want %b/%h", v, j, dig, seg,
                 exp_dig(k, m_valid), exp_seg(k, m_valid, m_val, m_dp));
      end
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_low v=%0d: got %b want 0", v, busy);
    end
    m_valid = 1'b1;
    m_val = v;
    m_dp = dp;
    for (int c = 0; c < int'(ND * CD); c++) begin
      @(negedge clk);
      tests_run++;
      if (dig !== exp_dig(k, m_valid)) begin
        tests_failed++;
        $display("FAIL scan_dig v=%0d k=%0d: got %b want %b", v, k, dig, exp_dig(k, m_valid));
      end
      tests_run++;
      if (seg !== exp_seg(k, m_valid, m_val, m_dp)) begin
        tests_failed++;
        $display("FAIL scan_seg v=%0d k=%0d: got %h want %h", v, k, seg,
                 exp_seg(k, m_valid, m_val, m_dp));
      end
      tests_run++;
      if (overflow !== (v >= p10(ND))) begin
        tests_failed++;
        $display("FAIL overflow v=%0d: got %b want %b", v, overflow, v >= p10(ND));
      end
    end
  endtask

  task automatic test_basic();
    test_value(123, 3'b000);
  endtask

  task automatic test_blanking();
    test_value(7, 3'b000);
    test_value(0, 3'b000);
    test_value(40, 3'b000);
  endtask

  task automatic test_overflow();
    test_value(1000, 3'b000);
    test_value(1023, 3'b101);
    test_value(999, 3'b000);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    value = VW'(456);
    dp_mask = '0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    value = VW'(789);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 3;
    while (busy === 1'b1 && n < 40) begin
      tests_run++;
      if (dig !== exp_dig(k, m_valid) || seg !== exp_seg(k, m_valid, m_val, m_dp)) begin
        tests_failed++;
        $display("FAIL b2b_hold n=%0d: dig=%b seg=%h want %b/%h", n, dig, seg,
                 exp_dig(k, m_valid), exp_seg(k, m_valid, m_val, m_dp));
      end
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != int'(VW) + 1) begin
      tests_failed++;
      $display("FAIL b2b_busy_len: busy fell after %0d cycles, want %0d", n, VW + 1);
    end
    m_valid = 1'b1;
    m_val = 456;
    m_dp = '0;
    value = VW'(321);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tests_run++;
      if (dig !== exp_dig(k, m_valid) || seg !== exp_seg(k, m_valid, m_val, m_dp)) begin
        tests_failed++;
        $display("FAIL b2b_show456 n=%0d: dig=%b seg=%h want %b/%h", n, dig, seg,
                 exp_dig(k, m_valid), exp_seg(k, m_valid, m_val, m_dp));
      end
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_timeout: busy=%b want 0", busy);
    end
    m_val = 321;
    for (int c = 0; c < int'(ND * CD); c++) begin
      @(negedge clk);
      tests_run++;
      if (dig !== exp_dig(k, m_valid) || seg !== exp_seg(k, m_valid, m_val, m_dp)) begin
        tests_failed++;
        $display("FAIL b2b_show321 k=%0d: dig=%b seg=%h want %b/%h", k, dig, seg,
                 exp_dig(k, m_valid), exp_seg(k, m_valid, m_val, m_dp));
      end
    end
  endtask

  task automatic test_dp_and_abort();
    test_value(5, 3'b010);
    @(negedge clk);
    value = VW'(555);
    dp_mask = 3'b111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || dig !== '0 || seg !== 8'hFF || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: busy=%b dig=%b seg=%h ovf=%b, want 0/000/ff/0",
               busy, dig, seg, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
    for (int c = 0; c < 2 * int'(ND * CD); c++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || dig !== '0 || seg !== 8'hFF) begin
        tests_failed++;
        $display("FAIL abort_blank c=%0d: busy=%b dig=%b seg=%h", c, busy, dig, seg);
      end
    end
    test_value(42, 3'b100);
  endtask

  task automatic test_random();
    int unsigned v;
    for (int r = 0; r < 16; r++) begin
      v = (r % 5 == 4) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
      test_value(v, ND'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_dp_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
